// File: rtl/stats_arb_sched_if.sv
// Stream bundle used on both sides of the statistics arbiter.
// LANES packs several independent streams side by side (one tvalid/tready pair per lane).
interface stats_arb_sched_if #(
  parameter int LANES      = 1,
  parameter int DATA_WIDTH = 16,
  parameter int ID_WIDTH   = 3
);
  logic [LANES*DATA_WIDTH-1:0] tdata;
  logic [LANES*ID_WIDTH-1:0]   tid;
  logic [LANES-1:0]            tvalid;
  logic [LANES-1:0]            tready;

  modport master (output tdata, tid, tvalid, input tready);
  modport slave  (input tdata, tid, tvalid, output tready);
endinterface

// File: rtl/stats_arb_sched.sv
// Round-robin merge of per-port statistics increments into one registered stream,
// plus a flush sequencer that staggers per-port update pulses.
module stats_arb_sched #(
  parameter int PORTS           = 4,
  parameter int STAT_INC_WIDTH  = 16,
  parameter int S_STAT_ID_WIDTH = 3,
  parameter int PORT_SEL_WIDTH  = $clog2(PORTS),
  parameter int M_STAT_ID_WIDTH = S_STAT_ID_WIDTH + PORT_SEL_WIDTH,
  parameter bit DROP_ZERO       = 1'b1,
  parameter int FLUSH_SPACING   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  stats_arb_sched_if.slave  s_axis_stat,
  stats_arb_sched_if.master m_axis_stat,
  input  logic              flush,
  output logic [PORTS-1:0]  stat_update,
  output logic              flush_busy
);

  localparam int CNT_WIDTH = (FLUSH_SPACING > 1) ? $clog2(FLUSH_SPACING) : 1;
  localparam logic [CNT_WIDTH-1:0]      CNT_RELOAD = CNT_WIDTH'(FLUSH_SPACING - 1);
  localparam logic [PORT_SEL_WIDTH-1:0] LAST_PORT  = PORT_SEL_WIDTH'(PORTS - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [PORT_SEL_WIDTH-1:0]  last_grant;
  logic [PORT_SEL_WIDTH-1:0]  grant;
  logic                       grant_valid;
  logic [PORT_SEL_WIDTH-1:0]  cand_sel;
  logic [STAT_INC_WIDTH-1:0]  sel_data;
  logic [S_STAT_ID_WIDTH-1:0] sel_id;
  logic                       can_accept;
  logic                       take;
  logic                       load;
  logic [PORTS-1:0]           s_ready;

  logic                       m_valid_reg;
  logic [STAT_INC_WIDTH-1:0]  m_data_reg;
  logic [M_STAT_ID_WIDTH-1:0] m_id_reg;

  logic [0:0]                 state;
  logic [PORT_SEL_WIDTH-1:0]  idx;
  logic [CNT_WIDTH-1:0]       cnt;
  logic                       pending;

  // Search starts one past the last granted port and wraps, so every port gets a turn.
  always_comb begin
    int cand;
    grant       = '0;
    grant_valid = 1'b0;
    cand        = 0;
    cand_sel    = '0;
    for (int k = 1; k <= PORTS; k++) begin
      cand = int'(last_grant) + k;
      if (cand >= PORTS) cand = cand - PORTS;
      cand_sel = PORT_SEL_WIDTH'(cand);
      if (!grant_valid && s_axis_stat.tvalid[cand_sel]) begin
        grant       = cand_sel;
        grant_valid = 1'b1;
      end
    end
  end

  assign sel_data   = s_axis_stat.tdata[grant*STAT_INC_WIDTH +: STAT_INC_WIDTH];
  assign sel_id     = s_axis_stat.tid[grant*S_STAT_ID_WIDTH +: S_STAT_ID_WIDTH];
  assign can_accept = !m_valid_reg || m_axis_stat.tready;
  assign take       = grant_valid && can_accept;
  assign load       = take && !(DROP_ZERO && (sel_data == '0));

  always_comb begin
    s_ready = '0;
    if (take) s_ready[grant] = 1'b1;
  end

  assign s_axis_stat.tready = s_ready;
  assign m_axis_stat.tvalid = m_valid_reg;
  assign m_axis_stat.tdata  = m_data_reg;
  assign m_axis_stat.tid    = m_id_reg;

  // Zero beats are consumed without loading but still move the pointer past their port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_reg <= 1'b0;
      m_data_reg  <= '0;
      m_id_reg    <= '0;
      last_grant  <= LAST_PORT;
    end else begin
      if (take) last_grant <= grant;
      if (load) begin
        m_valid_reg <= 1'b1;
        m_data_reg  <= sel_data;
        m_id_reg    <= {grant, sel_id};
      end else if (m_axis_stat.tready) begin
        m_valid_reg <= 1'b0;
      end
    end
  end

  // A flush during a run (including on the final pulse) queues exactly one rerun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      idx     <= '0;
      cnt     <= '0;
      pending <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (flush) begin
            state <= ST_RUN;
            idx   <= '0;
            cnt   <= '0;
          end
        end
        ST_RUN: begin
          pending <= pending || flush;
          if (cnt == '0) begin
            if (idx == LAST_PORT) begin
              idx <= '0;
              cnt <= '0;
              if (pending || flush) begin
                pending <= 1'b0;
              end else begin
                state <= ST_IDLE;
              end
            end else begin
              idx <= idx + 1'b1;
              cnt <= CNT_RELOAD;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    stat_update = '0;
    if (state == ST_RUN && cnt == '0) stat_update[idx] = 1'b1;
  end

  assign flush_busy = (state == ST_RUN);

endmodule

// File: tb/tb_stats_arb_sched.sv
// Directed bench for stats_arb_sched: arbitration order, backpressure, zero drop,
// flush staggering/queuing and asynchronous reset.
module tb_stats_arb_sched;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic [3:0] stat_update;
  logic       flush_busy;
  int         tests;
  int         fails;

  stats_arb_sched_if #(.LANES(4), .DATA_WIDTH(16), .ID_WIDTH(3)) s_if ();
  stats_arb_sched_if #(.LANES(1), .DATA_WIDTH(16), .ID_WIDTH(5)) m_if ();

  stats_arb_sched #(
    .PORTS(4), .STAT_INC_WIDTH(16), .S_STAT_ID_WIDTH(3),
    .DROP_ZERO(1'b1), .FLUSH_SPACING(16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_axis_stat (s_if),
    .m_axis_stat (m_if),
    .flush       (flush),
    .stat_update (stat_update),
    .flush_busy  (flush_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int port, input logic [15:0] data, input logic [2:0] id);
    s_if.tdata[port*16 +: 16] = data;
    s_if.tid[port*3 +: 3]     = id;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Flush at t=0 plus optional extra requests at f1/f2; a rerun starts at t=50 when expected.
  task automatic flushSequence(input string tag, input int f1, input int f2, input bit restart);
    logic [3:0] exp_upd;
    logic       exp_busy;
    int         last_t;
    last_t = restart ? 100 : 51;
    tick();
    flush = 1'b1;
    @(negedge clk);
    checkOutput($sformatf("%s_busy_t0", tag), 32'(flush_busy), 32'h0);
    for (int t = 1; t <= last_t; t++) begin
      tick();
      flush = (t == f1) || (t == f2);
      exp_upd  = 4'h0;
      exp_busy = 1'b0;
      if (t >= 1 && t <= 49) begin
        exp_busy = 1'b1;
        if ((t - 1) % 16 == 0) exp_upd = 4'(1 << ((t - 1) / 16));
      end
      if (restart && t >= 50 && t <= 98) begin
        exp_busy = 1'b1;
        if ((t - 50) % 16 == 0) exp_upd = 4'(1 << ((t - 50) / 16));
      end
      @(negedge clk);
      checkOutput($sformatf("%s_upd_t%0d", tag, t), 32'(stat_update), 32'(exp_upd));
      checkOutput($sformatf("%s_busy_t%0d", tag, t), 32'(flush_busy), 32'(exp_busy));
    end
    flush = 1'b0;
  endtask

  initial begin
    int p;
    tests       = 0;
    fails       = 0;
    rst_n       = 1'b0;
    flush       = 1'b0;
    s_if.tdata  = '0;
    s_if.tid    = '0;
    s_if.tvalid = '0;
    m_if.tready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_m_tvalid", 32'(m_if.tvalid), 32'h0);
    checkOutput("rst_m_tdata", 32'(m_if.tdata), 32'h0);
    checkOutput("rst_m_tid", 32'(m_if.tid), 32'h0);
    checkOutput("rst_stat_update", 32'(stat_update), 32'h0);
    checkOutput("rst_flush_busy", 32'(flush_busy), 32'h0);
    rst_n = 1'b1;

    // Single beat on port 2
    applyStimulus(2, 16'h0005, 3'd3);
    s_if.tvalid = 4'b0100;
    m_if.tready = 1'b1;
    @(negedge clk);
    checkOutput("single_s_tready", 32'(s_if.tready), 32'h4);
    tick();
    s_if.tvalid = 4'b0000;
    @(negedge clk);
    checkOutput("single_m_tvalid", 32'(m_if.tvalid), 32'h1);
    checkOutput("single_m_tdata", 32'(m_if.tdata), 32'h5);
    checkOutput("single_m_tid", 32'(m_if.tid), 32'h13);

    // All ports valid: pointer sits at 2, so grants run 3,0,1,2
    tick();
    for (int i = 0; i < 4; i++) applyStimulus(i, 16'(16'h10 + i), 3'(i));
    s_if.tvalid = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      p = (3 + k) % 4;
      checkOutput($sformatf("rr_s_tready_%0d", k), 32'(s_if.tready), 32'(1 << p));
      if (k > 0) begin
        p = (3 + k - 1) % 4;
        checkOutput($sformatf("rr_m_tdata_%0d", k), 32'(m_if.tdata), 32'(16'h10 + p));
        checkOutput($sformatf("rr_m_tid_%0d", k), 32'(m_if.tid), 32'((p << 3) | p));
      end
      tick();
    end
    s_if.tvalid = 4'b0000;
    @(negedge clk);
    checkOutput("rr_m_tdata_last", 32'(m_if.tdata), 32'h12);
    checkOutput("rr_m_tid_last", 32'(m_if.tid), 32'h12);
    tick();
    @(negedge clk);
    checkOutput("rr_drained", 32'(m_if.tvalid), 32'h0);

    // Backpressure with ports 0 and 1 valid; pointer at 2 so port 0 wins first
    tick();
    applyStimulus(0, 16'h00A0, 3'd1);
    applyStimulus(1, 16'h00B1, 3'd2);
    s_if.tvalid = 4'b0011;
    m_if.tready = 1'b0;
    @(negedge clk);
    checkOutput("bp_first_tready", 32'(s_if.tready), 32'h1);
    tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput($sformatf("bp_s_tready_%0d", i), 32'(s_if.tready), 32'h0);
      checkOutput($sformatf("bp_m_tvalid_%0d", i), 32'(m_if.tvalid), 32'h1);
      checkOutput($sformatf("bp_m_tdata_%0d", i), 32'(m_if.tdata), 32'hA0);
      checkOutput($sformatf("bp_m_tid_%0d", i), 32'(m_if.tid), 32'h01);
      tick();
    end
    m_if.tready = 1'b1;
    @(negedge clk);
    checkOutput("bp_release_tready", 32'(s_if.tready), 32'h2);
    tick();
    s_if.tvalid = 4'b0000;
    @(negedge clk);
    checkOutput("bp_next_tdata", 32'(m_if.tdata), 32'hB1);
    checkOutput("bp_next_tid", 32'(m_if.tid), 32'h0A);
    checkOutput("bp_next_tvalid", 32'(m_if.tvalid), 32'h1);

    // Zero beat is handshaken but never shows on the output
    tick();
    applyStimulus(1, 16'h0000, 3'd5);
    s_if.tvalid = 4'b0010;
    @(negedge clk);
    checkOutput("zero_s_tready", 32'(s_if.tready), 32'h2);
    tick();
    applyStimulus(1, 16'h0007, 3'd5);
    @(negedge clk);
    checkOutput("zero_no_output", 32'(m_if.tvalid), 32'h0);
    checkOutput("zero_next_tready", 32'(s_if.tready), 32'h2);
    tick();
    s_if.tvalid = 4'b0000;
    @(negedge clk);
    checkOutput("zero_after_tvalid", 32'(m_if.tvalid), 32'h1);
    checkOutput("zero_after_tdata", 32'(m_if.tdata), 32'h7);
    checkOutput("zero_after_tid", 32'(m_if.tid), 32'h0D);
    tick();
    @(negedge clk);
    checkOutput("zero_drained", 32'(m_if.tvalid), 32'h0);

    flushSequence("flush_single", -1, -1, 1'b0);
    flushSequence("flush_queued", 20, 30, 1'b1);
    flushSequence("flush_on_last", 49, -1, 1'b1);

    // Asynchronous reset in the middle of a flush with a beat held in the output
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (8) tick();
    applyStimulus(2, 16'h0055, 3'd1);
    s_if.tvalid = 4'b0100;
    m_if.tready = 1'b0;
    tick();
    @(negedge clk);
    checkOutput("pre_rst_m_tvalid", 32'(m_if.tvalid), 32'h1);
    checkOutput("pre_rst_flush_busy", 32'(flush_busy), 32'h1);
    tick();
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_m_tvalid", 32'(m_if.tvalid), 32'h0);
    checkOutput("arst_m_tdata", 32'(m_if.tdata), 32'h0);
    checkOutput("arst_m_tid", 32'(m_if.tid), 32'h0);
    checkOutput("arst_stat_update", 32'(stat_update), 32'h0);
    checkOutput("arst_flush_busy", 32'(flush_busy), 32'h0);
    s_if.tvalid = 4'b0000;
    m_if.tready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    for (int t = 0; t < 70; t++) begin
      @(negedge clk);
      checkOutput($sformatf("post_rst_upd_%0d", t), 32'(stat_update), 32'h0);
      tick();
    end
    checkOutput("post_rst_busy", 32'(flush_busy), 32'h0);
    for (int i = 0; i < 4; i++) applyStimulus(i, 16'h0001, 3'd0);
    s_if.tvalid = 4'b1111;
    @(negedge clk);
    checkOutput("post_rst_priority", 32'(s_if.tready), 32'h1);
    tick();
    s_if.tvalid = 4'b0000;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
